traffic_light_monitor: RTL and testbench



---
 rtl/traffic_light_monitor_pkg.sv | 39 +++
 rtl/traffic_light_monitor_tracker.sv | 146 ++++++++++++++
 rtl/traffic_light_monitor.sv | 123 ++++++++++++
 tb/tb_traffic_light_monitor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_monitor_pkg.sv
// traffic_monitor_pkg
// Shared definitions for the traffic light monitor: light codes as driven on
// La/Lb, the per-direction phase state type, and the err_code values.
// Build option: TLM_STARVE_CHECK_EN (see light_phase_tracker) enables the
// starvation check; the package itself is the same in both builds.
package traffic_monitor_pkg;

  // One-hot light codes on the controller's light interface
  localparam logic [2:0] CODE_RED    = 3'b100;
  localparam logic [2:0] CODE_YELLOW = 3'b010;
  localparam logic [2:0] CODE_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    S_UNKNOWN = 2'd0,
    S_RED     = 2'd1,
    S_YELLOW  = 2'd2,
    S_GREEN   = 2'd3
  } light_state_t;

  // err_code values; a lower value wins when several errors fire together
  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CONFLICT = 3'd1;
  localparam logic [2:0] ERR_SEQUENCE = 3'd2;
  localparam logic [2:0] ERR_YELLOW   = 3'd3;
  localparam logic [2:0] ERR_STARVE   = 3'd4;

  // Map a sampled light code to its phase; anything not one-hot is S_UNKNOWN
  function automatic light_state_t decode_light(input logic [2:0] code);
    light_state_t st;
    case (code)
      CODE_RED:    st = S_RED;
      CODE_YELLOW: st = S_YELLOW;
      CODE_GREEN:  st = S_GREEN;
      default:     st = S_UNKNOWN;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_tracker.sv
// light_phase_tracker
// Follows one direction's light phase and produces that direction's error
// strobes for the sampling tick (combinational, gated by tick; the top level
// registers them). Also keeps the RED->GREEN episode counter.
// Build option: TLM_STARVE_CHECK_EN adds the sensor wait counter and the
// starvation strobe; without it starve_s is constant 0.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   tick           sample enable
//   sensor         this direction's sensor
//   light[2:0]     this direction's light code
//   seq_err_s      illegal transition / invalid code on this tick
//   yellow_err_s   Y->R on this tick with wrong yellow length
//   starve_s       wait counter reaches MAX_WAIT on this tick
//   green_cnt[W]   completed RED->GREEN transitions, wraps
module light_phase_tracker
  import traffic_monitor_pkg::*;
#(
  parameter int YELLOW_TICKS = 3,
  parameter int MAX_WAIT     = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             sensor,
  input  logic [2:0]       light,
  output logic             seq_err_s,
  output logic             yellow_err_s,
  output logic             starve_s,
  output logic [CNT_W-1:0] green_cnt
);

  light_state_t     state_r;
  light_state_t     code_st_s;
  logic             legal_s;
  logic [CNT_W-1:0] ycnt_r;
  logic [CNT_W-1:0] green_cnt_r;

  assign code_st_s = decode_light(light);
  assign green_cnt = green_cnt_r;

  // Legal next phase from the current one (holding a phase is legal)
  always_comb begin
    legal_s = 1'b0;
    case (state_r)
      S_GREEN:  legal_s = (code_st_s == S_GREEN)  || (code_st_s == S_YELLOW);
      S_YELLOW: legal_s = (code_st_s == S_YELLOW) || (code_st_s == S_RED);
      S_RED:    legal_s = (code_st_s == S_RED)    || (code_st_s == S_GREEN);
      default:  legal_s = 1'b0;
    endcase
  end

  // Error strobes for this tick; an illegal exit from yellow is only a sequence error
  always_comb begin
    seq_err_s    = 1'b0;
    yellow_err_s = 1'b0;
    if (!tick) begin
      seq_err_s = 1'b0;
    end else if (state_r == S_UNKNOWN) begin
      seq_err_s = (code_st_s == S_UNKNOWN);
    end else if (!legal_s) begin
      seq_err_s = 1'b1;
    end else if ((state_r == S_YELLOW) && (code_st_s == S_RED)) begin
      yellow_err_s = (ycnt_r != CNT_W'(YELLOW_TICKS));
    end else begin
      yellow_err_s = 1'b0;
    end
  end

  // Phase FSM with yellow-length counter and green episode counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_UNKNOWN;
      ycnt_r      <= {CNT_W{1'b0}};
      green_cnt_r <= {CNT_W{1'b0}};
    end else if (tick) begin
      if (state_r == S_UNKNOWN) begin
        // First valid sample is taken as-is, no transition check
        state_r <= code_st_s;
        if (code_st_s == S_YELLOW) begin
          ycnt_r <= CNT_W'(1);
        end else begin
          ycnt_r <= ycnt_r;
        end
      end else if (!legal_s) begin
        state_r <= S_UNKNOWN;
      end else begin
        state_r <= code_st_s;
        if ((code_st_s == S_YELLOW) && (state_r != S_YELLOW)) begin
          ycnt_r <= CNT_W'(1);
        end else if ((code_st_s == S_YELLOW) && (ycnt_r != {CNT_W{1'b1}})) begin
          ycnt_r <= ycnt_r + CNT_W'(1);
        end else begin
          ycnt_r <= ycnt_r;
        end
        if ((state_r == S_RED) && (code_st_s == S_GREEN)) begin
          green_cnt_r <= green_cnt_r + CNT_W'(1);
        end else begin
          green_cnt_r <= green_cnt_r;
        end
      end
    end else begin
      state_r <= state_r;
    end
  end

`ifdef TLM_STARVE_CHECK_EN
  logic [CNT_W-1:0] wait_r;
  logic             waiting_s;

  assign waiting_s = sensor && (light != CODE_GREEN);

  // Strobe only on the tick that brings the counter up to MAX_WAIT
  always_comb begin
    starve_s = 1'b0;
    if (tick && waiting_s && (wait_r == CNT_W'(MAX_WAIT - 1))) begin
      starve_s = 1'b1;
    end else begin
      starve_s = 1'b0;
    end
  end

  // Wait counter: counts while served late, holds at MAX_WAIT, clears when served or idle
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_r <= {CNT_W{1'b0}};
    end else if (tick) begin
      if (!waiting_s) begin
        wait_r <= {CNT_W{1'b0}};
      end else if (wait_r != CNT_W'(MAX_WAIT)) begin
        wait_r <= wait_r + CNT_W'(1);
      end else begin
        wait_r <= wait_r;
      end
    end else begin
      wait_r <= wait_r;
    end
  end
`else
  logic [CNT_W-1:0] unused_wait_s;
  assign unused_wait_s = CNT_W'(MAX_WAIT) ^ {CNT_W{sensor}};
  assign starve_s      = 1'b0;
`endif

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Passive checker for the traffic light controller's light interface. Each
// direction's phase is tracked by a light_phase_tracker; this level adds the
// conflicting-green check, registers every error pulse one clock after the
// sampling tick, and keeps the sticky err_any and first-error err_code.
// Build option: TLM_STARVE_CHECK_EN enables starvation checking (err_starve,
// code 4); undefined, err_starve stays 0.
// Ports:
//   clk, reset         clock, synchronous active-high reset (wins over tick)
//   tick               sample enable
//   Sa, Sb             street sensors
//   La, Lb [2:0]       street light codes
//   err_conflict       pulse: both lights non-red
//   err_sequence       pulse: illegal transition or invalid code
//   err_yellow         pulse: wrong yellow length
//   err_starve         pulse: sensor waited MAX_WAIT ticks
//   err_any            sticky OR of all errors
//   err_code [2:0]     first error since reset
//   green_cnt_a/b      RED->GREEN counts per street
module traffic_light_monitor
  import traffic_monitor_pkg::*;
#(
  parameter int YELLOW_TICKS = 3,
  parameter int MAX_WAIT     = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             Sa,
  input  logic             Sb,
  input  logic [2:0]       La,
  input  logic [2:0]       Lb,
  output logic             err_conflict,
  output logic             err_sequence,
  output logic             err_yellow,
  output logic             err_starve,
  output logic             err_any,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] green_cnt_a,
  output logic [CNT_W-1:0] green_cnt_b
);

  logic       seq_a_s, seq_b_s, yel_a_s, yel_b_s, starve_a_s, starve_b_s;
  logic       conflict_s;
  logic [2:0] first_code_s;
  logic       err_conflict_r, err_sequence_r, err_yellow_r, err_starve_r;
  logic       err_any_r;
  logic [2:0] err_code_r;

  light_phase_tracker #(
    .YELLOW_TICKS(YELLOW_TICKS), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) u_track_a (
    .clk(clk), .reset(reset), .tick(tick), .sensor(Sa), .light(La),
    .seq_err_s(seq_a_s), .yellow_err_s(yel_a_s), .starve_s(starve_a_s),
    .green_cnt(green_cnt_a)
  );

  light_phase_tracker #(
    .YELLOW_TICKS(YELLOW_TICKS), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) u_track_b (
    .clk(clk), .reset(reset), .tick(tick), .sensor(Sb), .light(Lb),
    .seq_err_s(seq_b_s), .yellow_err_s(yel_b_s), .starve_s(starve_b_s),
    .green_cnt(green_cnt_b)
  );

  // Conflict check on raw codes, independent of either tracker's state
  always_comb begin
    conflict_s = 1'b0;
    if (tick) begin
      conflict_s = (La != CODE_RED) && (Lb != CODE_RED);
    end else begin
      conflict_s = 1'b0;
    end
  end

  // Highest-priority (lowest) error code present on this tick
  always_comb begin
    first_code_s = ERR_NONE;
    if (conflict_s) begin
      first_code_s = ERR_CONFLICT;
    end else if (seq_a_s || seq_b_s) begin
      first_code_s = ERR_SEQUENCE;
    end else if (yel_a_s || yel_b_s) begin
      first_code_s = ERR_YELLOW;
    end else if (starve_a_s || starve_b_s) begin
      first_code_s = ERR_STARVE;
    end else begin
      first_code_s = ERR_NONE;
    end
  end

  // Error pulse registers plus sticky summary, all updated in the same clock
  always_ff @(posedge clk) begin
    if (reset) begin
      err_conflict_r <= 1'b0;
      err_sequence_r <= 1'b0;
      err_yellow_r   <= 1'b0;
      err_starve_r   <= 1'b0;
      err_any_r      <= 1'b0;
      err_code_r     <= ERR_NONE;
    end else begin
      err_conflict_r <= conflict_s;
      err_sequence_r <= seq_a_s || seq_b_s;
      err_yellow_r   <= yel_a_s || yel_b_s;
      err_starve_r   <= starve_a_s || starve_b_s;
      err_any_r      <= err_any_r || (first_code_s != ERR_NONE);
      if (err_code_r == ERR_NONE) begin
        err_code_r <= first_code_s;
      end else begin
        err_code_r <= err_code_r;
      end
    end
  end

  assign err_conflict = err_conflict_r;
  assign err_sequence = err_sequence_r;
  assign err_yellow   = err_yellow_r;
  assign err_starve   = err_starve_r;
  assign err_any      = err_any_r;
  assign err_code     = err_code_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: directed scenarios then randomized
// light/sensor/tick/reset traffic. Each stimulus cycle pushes the expected
// outputs of a reference model onto a queue; a monitor pops one entry per
// clock after the edge and compares.
module tb_traffic_light_monitor;

  localparam int YT = 3;
  localparam int MW = 8;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       reset = 1'b1, tick = 1'b0, Sa = 1'b0, Sb = 1'b0;
  logic [2:0] La = 3'b100, Lb = 3'b100;
  logic       err_conflict, err_sequence, err_yellow, err_starve, err_any;
  logic [2:0] err_code;
  logic [7:0] green_cnt_a, green_cnt_b;

  traffic_light_monitor dut (
    .clk(clk), .reset(reset), .tick(tick), .Sa(Sa), .Sb(Sb), .La(La), .Lb(Lb),
    .err_conflict(err_conflict), .err_sequence(err_sequence),
    .err_yellow(err_yellow), .err_starve(err_starve), .err_any(err_any),
    .err_code(err_code), .green_cnt_a(green_cnt_a), .green_cnt_b(green_cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int conflict, seq, yel, starve, any, code, gca, gcb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit starve_en;

  // reference model: last accepted light per street (or none), run lengths
  bit         known[2];
  logic [2:0] prev[2];
  int         yrun[2], waitc[2], greens[2];
  int         m_any, m_code;

  function automatic bit is_valid(input logic [2:0] c);
    return (c == R) || (c == Y) || (c == G);
  endfunction

  function automatic bit allowed(input logic [2:0] p, input logic [2:0] c);
    return (p == c) || (p == G && c == Y) || (p == Y && c == R) || (p == R && c == G);
  endfunction

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      known[d] = 1'b0; prev[d] = 3'b000; yrun[d] = 0; waitc[d] = 0; greens[d] = 0;
    end
    m_any = 0; m_code = 0;
  endtask

  task automatic step(input bit r, input bit t, input bit sa, input bit sb,
                      input logic [2:0] la, input logic [2:0] lb);
    exp_t e;
    logic [2:0] cur[2];
    bit sens[2];
    int seq, yel, stv, con;
    @(negedge clk);
    reset = r; tick = t; Sa = sa; Sb = sb; La = la; Lb = lb;
    cur[0] = la; cur[1] = lb; sens[0] = sa; sens[1] = sb;
    seq = 0; yel = 0; stv = 0; con = 0;
    if (r) begin
      model_reset();
    end else if (t) begin
      con = (la != R) && (lb != R);
      for (int d = 0; d < 2; d++) begin
        if (!known[d]) begin
          if (is_valid(cur[d])) begin
            known[d] = 1'b1;
            prev[d] = cur[d];
            yrun[d] = (cur[d] == Y) ? 1 : 0;
          end else begin
            seq = 1;
          end
        end else if (!is_valid(cur[d]) || !allowed(prev[d], cur[d])) begin
          seq = 1;
          known[d] = 1'b0;
        end else begin
          if (prev[d] == Y && cur[d] == R && yrun[d] != YT) yel = 1;
          if (cur[d] == Y) yrun[d] = (prev[d] == Y) ? ((yrun[d] < 255) ? yrun[d] + 1 : 255) : 1;
          if (prev[d] == R && cur[d] == G) greens[d]++;
          prev[d] = cur[d];
        end
        if (starve_en && sens[d] && cur[d] != G) begin
          if (waitc[d] < MW) begin
            waitc[d]++;
            if (waitc[d] == MW) stv = 1;
          end
        end else begin
          waitc[d] = 0;
        end
      end
      if (m_code == 0) begin
        if (con) m_code = 1;
        else if (seq) m_code = 2;
        else if (yel) m_code = 3;
        else if (stv) m_code = 4;
      end
      if (con || seq || yel || stv) m_any = 1;
    end
    e.conflict = con; e.seq = seq; e.yel = yel; e.starve = stv;
    e.any = m_any; e.code = m_code;
    e.gca = greens[0] % 256; e.gcb = greens[1] % 256;
    q.push_back(e);
  endtask

  // wait for the last issued stimulus to be sampled and checked
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // monitor: outputs are presented every clock, one expected entry per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("err_conflict", int'(err_conflict), e.conflict);
        cmp("err_sequence", int'(err_sequence), e.seq);
        cmp("err_yellow", int'(err_yellow), e.yel);
        cmp("err_starve", int'(err_starve), e.starve);
        cmp("err_any", int'(err_any), e.any);
        cmp("err_code", int'(err_code), e.code);
        cmp("green_cnt_a", int'(green_cnt_a), e.gca);
        cmp("green_cnt_b", int'(green_cnt_b), e.gcb);
      end
    end
  end

  logic [2:0] wl[2];
  int         wrem[2];

  initial begin
    logic [2:0] code[2];
    bit r, t;
    int n;
`ifdef TLM_STARVE_CHECK_EN
    starve_en = 1'b1;
`else
    starve_en = 1'b0;
`endif
    model_reset();

    // 1: clean A green->yellow(3)->red while B waits red then goes green
    step(1, 1, 0, 0, R, R);
    step(1, 0, 0, 0, R, R);
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 0, (i < 4) ? G : ((i < 7) ? Y : R), (i < 7) ? R : G);
    settle();
    cmp("s1_code", int'(err_code), 0);
    cmp("s1_any", int'(err_any), 0);
    cmp("s1_green_b", int'(green_cnt_b), 1);

    // 2: A green with B yellow -> conflict
    step(0, 1, 0, 0, G, Y);
    settle();
    cmp("s2_code", int'(err_code), 1);
    cmp("s2_any", int'(err_any), 1);

    // 3: A G->R illegal, then R->G accepted as a fresh load
    step(1, 1, 0, 0, R, R);
    step(0, 1, 0, 0, G, R);
    step(0, 1, 0, 0, R, R);
    step(0, 1, 0, 0, G, R);
    settle();
    cmp("s3_code", int'(err_code), 2);

    // 4: short yellow, then a conflict that must not overwrite the code
    step(1, 1, 0, 0, R, R);
    step(0, 1, 0, 0, G, R);
    step(0, 1, 0, 0, Y, R);
    step(0, 1, 0, 0, Y, R);
    step(0, 1, 0, 0, R, R);
    step(0, 1, 0, 0, G, Y);
    settle();
    cmp("s4_code", int'(err_code), 3);

    // 5: B sensor waits on red for MAX_WAIT ticks and a few more
    step(1, 1, 0, 0, R, R);
    for (int i = 0; i < MW + 3; i++) step(0, 1, 0, 1, R, R);
    step(0, 1, 0, 0, R, R);
    settle();
    cmp("s5_code", int'(err_code), starve_en ? 4 : 0);

    // 6: reset mid-yellow with stall cycles; next sample is a fresh load
    step(1, 1, 0, 0, R, R);
    step(0, 1, 0, 0, G, R);
    step(0, 1, 0, 0, Y, R);
    step(0, 0, 0, 0, Y, R);
    step(0, 0, 0, 0, R, G);
    step(1, 1, 0, 0, Y, R);
    step(0, 1, 0, 0, R, R);
    step(0, 1, 0, 0, R, R);
    step(0, 1, 0, 0, G, R);
    settle();
    cmp("s6_code", int'(err_code), 0);
    cmp("s6_green_a", int'(green_cnt_a), 1);

    // randomized traffic: mostly legal walks with random durations
    wl[0] = G; wl[1] = R; wrem[0] = 2; wrem[1] = 3;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 59) == 0);
      t = ($urandom_range(0, 4) != 0);
      for (int d = 0; d < 2; d++) begin
        if (t) begin
          if (wrem[d] == 0) begin
            if (wl[d] == G) begin wl[d] = Y; wrem[d] = $urandom_range(1, 3); end
            else if (wl[d] == Y) begin wl[d] = R; wrem[d] = $urandom_range(0, 9); end
            else begin wl[d] = G; wrem[d] = $urandom_range(0, 5); end
          end else begin
            wrem[d]--;
          end
        end
        if ($urandom_range(0, 24) == 0) code[d] = 3'($urandom_range(0, 7));
        else code[d] = wl[d];
      end
      step(r, t, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), code[0], code[1]);
    end

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
